mpeg_input_stream_fifo_ctrl: RTL and testbench



---
 rtl/mpeg_input_stream_fifo_ctrl_pkg.sv | 18 +
 rtl/mpeg_input_stream_fifo_ctrl_if.sv | 28 ++
 rtl/mpeg_input_stream_fifo_ctrl_ram.sv | 29 ++
 rtl/mpeg_input_stream_fifo_ctrl.sv | 112 +++++++++++
 tb/tb_mpeg_input_stream_fifo_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpeg_input_stream_fifo_ctrl_pkg.sv
// rtl/mpeg_input_stream_fifo_ctrl_pkg.sv - shared types and constants for the MPEG input stream FIFO
// Contents: FIFO geometry, controller state encoding, pointer/count types.
package mpeg_fifo_pkg;

  localparam int unsigned FIFO_BYTES = 8192;
  localparam int unsigned FIFO_WORDS = 2048;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fifo_state_e;

  // Pointers carry one extra wrap bit above the RAM address.
  typedef logic [13:0] byte_ptr_t;
  typedef logic [11:0] word_ptr_t;
  // 0..8192 inclusive, so 14 bits.
  typedef logic [13:0] byte_count_t;

  localparam byte_count_t WORD_BYTES = 14'd4;

endpackage

// File: rtl/mpeg_input_stream_fifo_ctrl_if.sv
// rtl/mpeg_input_stream_fifo_ctrl_if.sv - stream, flush and status bundle for the MPEG input FIFO
// master: upstream writer + parser side (drives flush, in_*, out_ready)
// slave : FIFO controller (drives in_ready, out_*, byte_count, almost_full, empty_words)
interface mpeg_input_stream_fifo_ctrl_if;
  import mpeg_fifo_pkg::*;

  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  byte_count_t byte_count;
  logic        almost_full;
  logic        empty_words;

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, byte_count, almost_full, empty_words
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, byte_count, almost_full, empty_words
  );

endinterface

// File: rtl/mpeg_input_stream_fifo_ctrl_ram.sv
// rtl/mpeg_input_stream_fifo_ctrl_ram.sv - 8 KB mixed-width FIFO RAM (8192x8 write, 2048x32 read)
// Ports: clk; we/waddr[12:0]/wdata[7:0] byte write; re/raddr[10:0] word read;
//        q[31:0] valid the cycle after re. Contents are not reset.
module mpeg_input_stream_fifo_8k
  import mpeg_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [12:0] waddr,
  input  logic [7:0]  wdata,
  input  logic        re,
  input  logic [10:0] raddr,
  output logic [31:0] q
);

  // Four byte lanes per word; byte address bits [1:0] select the lane so
  // stream byte 0 lands in q[7:0].
  logic [3:0][7:0] mem [FIFO_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[12:2]][waddr[1:0]] <= wdata;
    end
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/mpeg_input_stream_fifo_ctrl.sv
// rtl/mpeg_input_stream_fifo_ctrl.sv - byte-in / word-out sequencing controller for the MPEG input FIFO
// Ports: clk, reset (sync, active-high); strm (slave modport): flush, in_data/in_valid/in_ready
//        byte stream in, out_data/out_valid/out_ready word stream out, byte_count, almost_full,
//        empty_words status. Parameter ALMOST_FULL_BYTES sets the almost_full threshold.
module mpeg_input_stream_fifo_ctrl
  import mpeg_fifo_pkg::*;
#(
  parameter int unsigned ALMOST_FULL_BYTES = 7168
) (
  input logic                          clk,
  input logic                          reset,
  mpeg_input_stream_fifo_ctrl_if.slave strm
);

  fifo_state_e state, next_state;
  byte_ptr_t   wptr;
  word_ptr_t   rptr;
  byte_count_t count;
  logic [31:0] out_data_q;
  logic        out_valid_q;
  logic [31:0] ram_q;
  logic        wr_en;
  logic        rd_en;
  logic        word_avail;

  // Fetch decisions use the registered count, so a word completed at this
  // edge is only read next cycle and RAM read-during-write is never seen.
  assign word_avail = (count >= WORD_BYTES);
  assign wr_en      = strm.in_valid && strm.in_ready && !strm.flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (strm.flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (word_avail) next_state = FETCH;
        FETCH:   next_state = HOLD;
        HOLD:    if (strm.out_ready) next_state = word_avail ? FETCH : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output logic: read issue. A HOLD handoff issues the next fetch in the
  // same cycle the consumer takes the current word.
  always_comb begin
    rd_en = 1'b0;
    if (!strm.flush) begin
      case (state)
        IDLE:    rd_en = word_avail;
        HOLD:    rd_en = strm.out_ready && word_avail;
        default: rd_en = 1'b0;
      endcase
    end
  end

  // Datapath. RAM space is released at fetch; the word itself lives in
  // out_data_q, so the writer may overwrite the RAM slot during HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (strm.flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= count + byte_count_t'(wr_en) - (rd_en ? WORD_BYTES : '0);
      if (state == FETCH) out_data_q <= ram_q;
      out_valid_q <= (next_state == HOLD);
    end
  end

  // Wrap bits are kept for debug visibility; full/empty come from count.
  logic unused_wrap_bits;
  assign unused_wrap_bits = ^{wptr[13], rptr[11]};

  assign strm.in_ready    = (count != byte_count_t'(FIFO_BYTES));
  assign strm.out_data    = out_data_q;
  assign strm.out_valid   = out_valid_q;
  assign strm.byte_count  = count;
  assign strm.almost_full = (count >= byte_count_t'(ALMOST_FULL_BYTES));
  assign strm.empty_words = !word_avail;

  mpeg_input_stream_fifo_8k u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[12:0]),
    .wdata (strm.in_data),
    .re    (rd_en),
    .raddr (rptr[10:0]),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_mpeg_input_stream_fifo_ctrl.sv
// tb/tb_mpeg_input_stream_fifo_ctrl.sv - testbench for mpeg_input_stream_fifo_ctrl
module tb_mpeg_input_stream_fifo_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mpeg_input_stream_fifo_ctrl_if bus ();

  mpeg_input_stream_fifo_ctrl #(.ALMOST_FULL_BYTES(7168)) dut (
    .clk   (clk),
    .reset (reset),
    .strm  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q_model[$];

  // Reference: every accepted byte is queued; every word handed to the
  // consumer is the next four queued bytes, byte 0 in the low lane.
  function automatic logic [31:0] pop_word();
    logic [31:0] w;
    w = 'x;
    if (q_model.size() >= 4) begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = q_model.pop_front();
    end
    return w;
  endfunction

  task automatic step(output bit acc, output bit xfer, output logic [31:0] word);
    acc  = bus.in_valid && bus.in_ready && !bus.flush && !reset;
    xfer = bus.out_valid && bus.out_ready && !bus.flush && !reset;
    word = bus.out_data;
    if (reset || bus.flush) q_model.delete();
    else if (acc) q_model.push_back(bus.in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.flush = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    q_model.delete();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.byte_count !== 14'd0) begin n_fail++; $display("FAIL reset_byte_count: got %0d want 0", bus.byte_count); end
    n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
    n_checks++; if (bus.empty_words !== 1'b1) begin n_fail++; $display("FAIL reset_empty_words: got %b want 1", bus.empty_words); end
  endtask

  task automatic test_basic();
    bit acc, xfer;
    logic [31:0] w, exp;
    int words = 0, run = 0, max_run = 0;
    bus.out_ready = 1;
    for (int c = 0; c < 40; c++) begin
      bus.in_valid = (c < 8);
      bus.in_data  = 8'(c + 1);
      step(acc, xfer, w);
      if (xfer) begin
        exp = pop_word();
        n_checks++;
        if (w !== ((words == 0) ? 32'h04030201 : 32'h08070605)) begin
          n_fail++; $display("FAIL basic_word%0d: got %h model %h", words, w, exp);
        end
        words++;
      end
      run = bus.out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    bus.in_valid = 0;
    n_checks++; if (words != 2) begin n_fail++; $display("FAIL basic_word_count: got %0d want 2", words); end
    n_checks++; if (max_run != 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d want 1", max_run); end
    n_checks++; if (bus.byte_count !== 14'd0) begin n_fail++; $display("FAIL basic_byte_count: got %0d want 0", bus.byte_count); end
  endtask

  task automatic test_partial();
    bit acc, xfer, seen = 0;
    logic [31:0] w, exp;
    bus.out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c < 3);
      bus.in_data  = 8'($urandom);
      step(acc, xfer, w);
      if (bus.out_valid) seen = 1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL partial_no_output: got out_valid=1 want 0"); end
    n_checks++; if (bus.byte_count !== 14'd3) begin n_fail++; $display("FAIL partial_byte_count: got %0d want 3", bus.byte_count); end
    n_checks++; if (bus.empty_words !== 1'b1) begin n_fail++; $display("FAIL partial_empty_words: got %b want 1", bus.empty_words); end
    bus.in_valid = 1; bus.in_data = 8'($urandom);
    step(acc, xfer, w);
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_lat1: got %b want 0", bus.out_valid); end
    step(acc, xfer, w);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_lat2: got %b want 0", bus.out_valid); end
    step(acc, xfer, w);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL partial_lat3: got %b want 1", bus.out_valid); end
    step(acc, xfer, w);
    exp = pop_word();
    n_checks++; if (!xfer || w !== exp) begin n_fail++; $display("FAIL partial_word: got %h (xfer %b) want %h", w, xfer, exp); end
    repeat (3) step(acc, xfer, w);
    n_checks++; if (bus.byte_count !== 14'd0) begin n_fail++; $display("FAIL partial_drain: got %0d want 0", bus.byte_count); end
  endtask

  task automatic test_full();
    bit acc, xfer;
    logic [31:0] w, exp;
    int n = 0, cyc = 0;
    bus.out_ready = 0; bus.in_valid = 1;
    while (bus.in_ready && cyc < 9000) begin
      bus.in_data = 8'($urandom);
      step(acc, xfer, w);
      cyc++;
      if (acc) begin
        n++;
        if (n == 7171) begin
          n_checks++;
          if (bus.byte_count !== 14'd7167 || bus.almost_full !== 1'b0) begin
            n_fail++; $display("FAIL full_below_af: got count %0d af %b want 7167 0", bus.byte_count, bus.almost_full);
          end
        end
        if (n == 7172) begin
          n_checks++;
          if (bus.byte_count !== 14'd7168 || bus.almost_full !== 1'b1) begin
            n_fail++; $display("FAIL full_at_af: got count %0d af %b want 7168 1", bus.byte_count, bus.almost_full);
          end
        end
      end
    end
    bus.in_valid = 0;
    n_checks++; if (n != 8196) begin n_fail++; $display("FAIL full_accepted: got %0d want 8196", n); end
    n_checks++; if (bus.byte_count !== 14'd8192) begin n_fail++; $display("FAIL full_byte_count: got %0d want 8192", bus.byte_count); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.almost_full !== 1'b1) begin n_fail++; $display("FAIL full_almost_full: got %b want 1", bus.almost_full); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_held: got %b want 1", bus.out_valid); end
    bus.out_ready = 1;
    step(acc, xfer, w);
    exp = pop_word();
    n_checks++; if (!xfer || w !== exp) begin n_fail++; $display("FAIL full_first_word: got %h want %h", w, exp); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.byte_count !== 14'd8188) begin
      n_fail++; $display("FAIL full_release: got in_ready %b count %0d want 1 8188", bus.in_ready, bus.byte_count);
    end
    cyc = 0;
    while (q_model.size() > 0 && cyc < 20000) begin
      step(acc, xfer, w);
      cyc++;
      if (xfer) begin
        exp = pop_word();
        n_checks++; if (w !== exp) begin n_fail++; $display("FAIL full_drain_word: got %h want %h", w, exp); end
      end
    end
    n_checks++; if (q_model.size() != 0 || bus.byte_count !== 14'd0) begin
      n_fail++; $display("FAIL full_drain_done: got %0d left count %0d want 0 0", q_model.size(), bus.byte_count);
    end
  endtask

  task automatic test_wrap_stream();
    bit acc, xfer;
    logic [31:0] w, exp;
    int sent = 0, words = 0, cyc = 0, diff;
    while (words < 6144 && cyc < 80000) begin
      bus.in_valid  = (sent < 24576) && ($urandom_range(0, 7) != 0);
      bus.in_data   = 8'(sent);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(acc, xfer, w);
      cyc++;
      if (acc) sent++;
      if (xfer) begin
        exp = pop_word();
        n_checks++; if (w !== exp) begin n_fail++; $display("FAIL wrap_word%0d: got %h want %h", words, w, exp); end
        words++;
      end
      // At most one word sits between RAM and consumer.
      diff = q_model.size() - int'(bus.byte_count);
      n_checks++;
      if (!((diff == 0 && !bus.out_valid) || diff == 4)) begin
        n_fail++; $display("FAIL wrap_occupancy: got pending-count %0d out_valid %b want 0 or 4", diff, bus.out_valid);
      end
    end
    bus.in_valid = 0; bus.out_ready = 1;
    n_checks++; if (words != 6144) begin n_fail++; $display("FAIL wrap_word_count: got %0d want 6144", words); end
    n_checks++; if (bus.byte_count !== 14'd0) begin n_fail++; $display("FAIL wrap_final_count: got %0d want 0", bus.byte_count); end
  endtask

  task automatic test_flush();
    bit acc, xfer, found = 0;
    logic [31:0] w, got = '0, exp;
    logic [7:0] seq [4];
    seq[0] = 8'hAA; seq[1] = 8'hBB; seq[2] = 8'hCC; seq[3] = 8'hDD;
    bus.out_ready = 0; bus.in_valid = 1;
    for (int c = 0; c < 100; c++) begin
      bus.in_data = 8'($urandom);
      step(acc, xfer, w);
    end
    bus.in_valid = 0;
    step(acc, xfer, w);
    step(acc, xfer, w);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.byte_count !== 14'd96) begin
      n_fail++; $display("FAIL flush_setup: got out_valid %b count %0d want 1 96", bus.out_valid, bus.byte_count);
    end
    bus.flush = 1; bus.in_valid = 1; bus.in_data = 8'h55; bus.out_ready = 1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    step(acc, xfer, w);
    bus.flush = 0; bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.byte_count !== 14'd0) begin n_fail++; $display("FAIL flush_byte_count: got %0d want 0", bus.byte_count); end
    n_checks++; if (bus.empty_words !== 1'b1) begin n_fail++; $display("FAIL flush_empty_words: got %b want 1", bus.empty_words); end
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1; bus.in_data = seq[c];
      step(acc, xfer, w);
    end
    bus.in_valid = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(acc, xfer, w);
      if (xfer) begin found = 1; got = w; end
    end
    exp = pop_word();
    n_checks++; if (!found || got !== 32'hDDCCBBAA) begin
      n_fail++; $display("FAIL flush_new_word: got %h (seen %b) want ddccbbaa model %h", got, found, exp);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, xfer, seen = 0;
    logic [31:0] w;
    bus.out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1; bus.in_data = 8'($urandom);
      step(acc, xfer, w);
    end
    bus.in_valid = 0;
    step(acc, xfer, w);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_fetch_valid: got %b want 0", bus.out_valid); end
    reset = 1;
    step(acc, xfer, w);
    reset = 0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rmid_out_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.byte_count !== 14'd0) begin n_fail++; $display("FAIL rmid_byte_count: got %0d want 0", bus.byte_count); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.almost_full !== 1'b0 || bus.empty_words !== 1'b1) begin
      n_fail++; $display("FAIL rmid_status: got rdy %b af %b ew %b want 1 0 1", bus.in_ready, bus.almost_full, bus.empty_words);
    end
    for (int c = 0; c < 6; c++) begin
      step(acc, xfer, w);
      if (bus.out_valid) seen = 1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rmid_discarded: got out_valid=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_full();
    test_wrap_stream();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
